// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM,
// one-cycle write strobe or framing-error strobe per frame.
module uart_rx #(
    parameter int CyclesPerBit = 868,
    parameter int HalfBit      = CyclesPerBit / 2
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data,
    output logic       write_enable,
    output logic       frame_error,
    output logic       busy
);

    localparam int CW = $clog2(CyclesPerBit);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CyclesPerBit - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HalfBit - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          s1;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx_i;
            rx_s <= s1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            data         <= '0;
            write_enable <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            write_enable <= 1'b0;
            frame_error  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            data         <= shreg;
                            write_enable <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            frame_error <= 1'b1;
                            state       <= BRK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BRK: begin
                    // A held-low line must rise before a new start is accepted
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 cycles per bit: good frames,
// back-to-back frames, start glitch, framing error and mid-frame reset.
module tb_uart_rx;

    logic       clk_i;
    logic       reset_i;
    logic       rx_i;
    logic [7:0] data;
    logic       write_enable;
    logic       frame_error;
    logic       busy;

    int n_cmp;
    int n_bad;

    int         cyc;
    int         we_cnt;
    int         fe_cnt;
    int         both_cnt;
    int         busy_cnt;
    int         we_cyc_log [0:15];
    logic [7:0] we_dat_log [0:15];

    uart_rx #(.CyclesPerBit(16)) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .rx_i         (rx_i),
        .data         (data),
        .write_enable (write_enable),
        .frame_error  (frame_error),
        .busy         (busy)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        we_cnt   = 0;
        fe_cnt   = 0;
        both_cnt = 0;
        busy_cnt = 0;
    end

    always @(negedge clk_i) begin
        if (write_enable === 1'b1) begin
            if (we_cnt < 16) begin
                we_cyc_log[we_cnt] <= cyc;
                we_dat_log[we_cnt] <= data;
            end
            we_cnt <= we_cnt + 1;
        end
        if (frame_error === 1'b1) fe_cnt <= fe_cnt + 1;
        if (write_enable === 1'b1 && frame_error === 1'b1)
            both_cnt <= both_cnt + 1;
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_bit();
        repeat (16) @(posedge clk_i);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop,
                              output int t0);
        rx_i = 1'b0;
        t0 = cyc;
        hold_bit();
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            hold_bit();
        end
        rx_i = stop;
        hold_bit();
    endtask

    int t0, t1, t2;
    int we0, fe0, b0;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rx_i    = 1'b1;
        reset_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;

        chk("rst_data", data, 8'h00);
        chk("rst_we", write_enable, 1'b0);
        chk("rst_fe", frame_error, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // single good frame
        we0 = we_cnt;
        send_frame(8'hA5, 1'b1, t0);
        repeat (8) @(posedge clk_i);
        #1;
        chk("a5_count", we_cnt - we0, 1);
        chk("a5_latency", we_cyc_log[we0] - t0, 155);
        chk("a5_data", we_dat_log[we0], 8'hA5);
        chk("a5_no_fe", fe_cnt, 0);

        // back-to-back frames
        we0 = we_cnt;
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t1);
        send_frame(8'h3C, 1'b1, t2);
        repeat (8) @(posedge clk_i);
        #1;
        chk("b2b_count", we_cnt - we0, 3);
        chk("b2b_d0", we_dat_log[we0], 8'h00);
        chk("b2b_d1", we_dat_log[we0 + 1], 8'hFF);
        chk("b2b_d2", we_dat_log[we0 + 2], 8'h3C);
        chk("b2b_gap01", we_cyc_log[we0 + 1] - we_cyc_log[we0], 160);
        chk("b2b_gap12", we_cyc_log[we0 + 2] - we_cyc_log[we0 + 1], 160);

        // start glitch
        we0 = we_cnt;
        fe0 = fe_cnt;
        b0  = busy_cnt;
        rx_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rx_i = 1'b1;
        repeat (24) @(posedge clk_i);
        #1;
        chk("glitch_busy_cycles", busy_cnt - b0, 8);
        chk("glitch_no_we", we_cnt - we0, 0);
        chk("glitch_no_fe", fe_cnt - fe0, 0);
        chk("glitch_idle", busy, 1'b0);

        // framing error, then break held low
        we0 = we_cnt;
        fe0 = fe_cnt;
        send_frame(8'h55, 1'b0, t0);
        repeat (40) @(posedge clk_i);
        #1;
        chk("fe_count", fe_cnt - fe0, 1);
        chk("fe_no_we", we_cnt - we0, 0);
        chk("fe_data_kept", data, 8'h3C);
        chk("fe_break_busy", busy, 1'b1);
        rx_i = 1'b1;
        repeat (6) @(posedge clk_i);
        #1;
        chk("fe_break_exit", busy, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        send_frame(8'h12, 1'b1, t0);
        repeat (8) @(posedge clk_i);
        #1;
        chk("after_fe_count", we_cnt - we0, 1);
        chk("after_fe_data", data, 8'h12);

        // reset in the middle of 0x81
        we0 = we_cnt;
        fe0 = fe_cnt;
        rx_i = 1'b0;
        hold_bit();
        for (int i = 0; i < 4; i++) begin
            rx_i = (8'h81 >> i) & 8'h01;
            hold_bit();
        end
        rx_i = 1'b0;
        repeat (8) @(posedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_data", data, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_we", write_enable, 1'b0);
        chk("arst_fe", frame_error, 1'b0);
        rx_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;
        repeat (20) @(posedge clk_i);
        #1;
        chk("arst_no_strobe", we_cnt - we0, 0);
        send_frame(8'h7E, 1'b1, t0);
        repeat (8) @(posedge clk_i);
        #1;
        chk("post_rst_count", we_cnt - we0, 1);
        chk("post_rst_data", data, 8'h7E);
        chk("post_rst_latency", we_cyc_log[we0] - t0, 155);
        chk("post_rst_no_fe", fe_cnt - fe0, 0);

        chk("strobes_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
